// File: rtl/data_ram_resp.sv
// Wait-state data RAM responder: captures one request from IDLE, holds it through
// WAIT_CYCLES wait states, then completes it in a single ACCESS cycle with a ready pulse.
module data_ram_resp #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] mem [DEPTH];

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        capture;

  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_data;
  logic [31:0] data_q;

  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic [31:0]           rd_word;

  assign idx      = req_addr[ADDR_WIDTH+1:2];
  assign in_range = ((req_addr >> (ADDR_WIDTH + 2)) == 32'd0);
  assign rd_word  = in_range ? mem[idx] : 32'h0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_ce_i) begin
          capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end else begin
            state_nxt = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_ACCESS;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ACCESS: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      req_we   <= 1'b0;
      req_addr <= 32'h0;
      req_sel  <= 4'h0;
      req_data <= 32'h0;
      data_q   <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        req_we   <= mem_we_i;
        req_addr <= mem_addr_i;
        req_sel  <= mem_sel_i;
        req_data <= mem_data_i;
      end
      if (state == S_ACCESS && !req_we) data_q <= rd_word;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && req_we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel[b]) mem[idx][8*b +: 8] <= req_data[8*b +: 8];
      end
    end
  end

  // Read data is presented during the ready cycle and held afterwards in data_q.
  assign mem_ready_o = (state == S_ACCESS);
  assign mem_err_o   = mem_ready_o && !in_range;
  assign mem_data_o  = (mem_ready_o && !req_we) ? rd_word : data_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed self-checking bench for data_ram_resp with WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_data_ram_resp;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        ce = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, data = '0;
  logic [3:0]  sel = '0;
  logic [31:0] rdata;
  logic        ready, err;

  logic        ce0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, data0 = '0;
  logic [3:0]  sel0 = '0;
  logic [31:0] rdata0;
  logic        ready0, err0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .mem_ce_i(ce), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(data), .mem_data_o(rdata),
    .mem_ready_o(ready), .mem_err_o(err)
  );

  data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_ce_i(ce0), .mem_we_i(we0), .mem_addr_i(addr0),
    .mem_sel_i(sel0), .mem_data_i(data0), .mem_data_o(rdata0),
    .mem_ready_o(ready0), .mem_err_o(err0)
  );

  // One request on the W=2 instance; request inputs are scrambled right after capture.
  task automatic do_req(input string name, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d, input logic exp_err,
                        input logic chk_data, input logic [31:0] exp_data);
    int  lat;
    bit  got;
    @(negedge clk);
    ce = 1'b1; we = w; addr = a; sel = s; data = d;
    @(posedge clk);
    #1;
    ce = 1'b0; we = ~w; addr = $urandom; sel = 4'($urandom); data = $urandom;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ready === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || lat != W + 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles (seen=%0d), expected %0d", name, lat, got, W + 1);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s_err: got %b, expected %b", name, err, exp_err);
    end
    if (chk_data) begin
      checks++;
      if (rdata !== exp_data) begin
        errors++;
        $display("FAIL %s_data: got %h, expected %h", name, rdata, exp_data);
      end
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse_width: ready=%b err=%b, expected 0 0", name, ready, err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b err=%b data=%h, expected 0 0 00000000", ready, err, rdata);
    end
    checks++;
    if (ready0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs_w0: ready=%b err=%b data=%h, expected 0 0 00000000", ready0, err0, rdata0);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    do_req("wr_full", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0);
    do_req("rd_full", 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
  endtask

  task automatic test_byte_lanes;
    do_req("wr_lane2", 1'b1, 32'h12, 4'b0100, 32'h55555555, 1'b0, 1'b1, 32'hDEADBEEF);
    do_req("rd_lane2", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b1, 32'hDE55BEEF);
    do_req("wr_sel0", 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hDE55BEEF);
    do_req("rd_sel0", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b1, 32'hDE55BEEF);
  endtask

  task automatic test_out_of_range;
    do_req("wr_word0", 1'b1, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0);
    do_req("rd_oor", 1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0);
    do_req("wr_oor", 1'b1, 32'h1000, 4'hF, 32'h11111111, 1'b1, 1'b0, 32'h0);
    do_req("rd_word0", 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5);
  endtask

  task automatic test_reset_abort;
    int pulses;
    do_req("wr_prior", 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; data = 32'h12345678;
    @(posedge clk);
    #1 ce = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready !== 1'b0) pulses++;
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL abort_data_in_reset: got %h, expected 00000000", rdata);
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ready !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_no_ready: got %0d ready cycles, expected 0", pulses);
    end
    do_req("rd_after_abort", 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
  endtask

  // Write then read with ce held high: the read is captured in the IDLE cycle after ready.
  task automatic test_back_to_back;
    int idx, first, second;
    first = -1;
    second = -1;
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = 32'h30; sel = 4'hF; data = 32'h0BADCAFE;
    @(posedge clk);
    #1 we = 1'b0; data = 32'h77777777;
    idx = 0;
    while (second < 0 && idx < 20) begin
      @(negedge clk);
      idx++;
      if (ready === 1'b1) begin
        if (first < 0) first = idx;
        else begin
          second = idx;
          ce = 1'b0;
          checks++;
          if (rdata !== 32'h0BADCAFE) begin
            errors++;
            $display("FAIL b2b_read_data: got %h, expected 0BADCAFE", rdata);
          end
        end
      end
    end
    checks++;
    if (first != W + 1 || second != first + W + 2) begin
      errors++;
      $display("FAIL b2b_spacing: ready at %0d and %0d, expected %0d and %0d", first, second, W + 1, 2 * W + 3);
    end
    ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait0;
    logic        tw [4];
    logic [31:0] td [4];
    tw = '{1'b1, 1'b0, 1'b1, 1'b0};
    td = '{32'h13572468, 32'hFFFF0000, 32'h2468ACE0, 32'h0000FFFF};
    @(negedge clk);
    ce0 = 1'b1; we0 = tw[0]; addr0 = 32'h40; sel0 = 4'hF; data0 = td[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) begin
        we0 = tw[i+1]; data0 = td[i+1]; sel0 = 4'hF;
      end else begin
        ce0 = 1'b0; we0 = 1'b1; data0 = 32'hBAD0BAD0;
      end
      @(negedge clk);
      checks++;
      if (ready0 !== 1'b1 || err0 !== 1'b0) begin
        errors++;
        $display("FAIL w0_ready_%0d: ready=%b err=%b, expected 1 0", i, ready0, err0);
      end
      if (!tw[i]) begin
        checks++;
        if (rdata0 !== td[i-1]) begin
          errors++;
          $display("FAIL w0_read_%0d: got %h, expected %h", i, rdata0, td[i-1]);
        end
      end
      @(negedge clk);
      checks++;
      if (ready0 !== 1'b0) begin
        errors++;
        $display("FAIL w0_gap_%0d: ready=%b, expected 0", i, ready0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_reset_abort();
    test_back_to_back();
    test_wait0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
